// File: rtl/micro32_dmem_pipe.sv
// Pipelined byte-enabled data memory for the micro32 MEM stage, with a priority preload port.
// Define MICRO32_DMEM_BOUNDS_EN to enable out-of-range detection and the rsp_err flag.
module micro32_dmem_pipe #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned DEPTH  = 1024,
    parameter int unsigned RD_LAT = 2
) (
    input  logic                  clk1,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    input  logic [DATA_W/8-1:0]   req_be,
    input  logic                  ld_en,
    input  logic [ADDR_W-1:0]     ld_addr,
    input  logic [DATA_W-1:0]     ld_data,
    output logic                  rsp_valid,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic                  rsp_err
);

    localparam int unsigned BE_W = DATA_W / 8;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              accept;
    logic              load_acc;
    logic              req_ok;
    logic              ld_ok;

    logic [RD_LAT-1:0] pipe_valid;
    logic [DATA_W-1:0] pipe_data [RD_LAT];

    // Preload owns the array port for the cycle, so requests stall while it is active.
    assign req_ready = !rst && !ld_en;
    assign accept    = req_valid && req_ready;
    assign load_acc  = accept && !req_we;

`ifdef MICRO32_DMEM_BOUNDS_EN
    logic [RD_LAT-1:0] pipe_err;
    logic              st_err;

    assign req_ok = 64'(req_addr) < 64'(DEPTH);
    assign ld_ok  = 64'(ld_addr) < 64'(DEPTH);
`else
    assign req_ok = 1'b1;
    assign ld_ok  = 1'b1;
`endif

    // Storage array: never reset, so contents survive a pipeline reset.
    always_ff @(posedge clk1) begin
        if (ld_en && ld_ok) begin
            mem[ld_addr] <= ld_data;
        end else if (accept && req_we && req_ok) begin
            for (int i = 0; i < int'(BE_W); i++) begin
                if (req_be[i]) begin
                    mem[req_addr][8*i +: 8] <= req_wdata[8*i +: 8];
                end
            end
        end
    end

    // Read-latency shift pipeline; stage 0 captures the word at the accept edge.
    always_ff @(posedge clk1) begin
        if (rst) begin
            pipe_valid <= '0;
            for (int i = 0; i < int'(RD_LAT); i++) begin
                pipe_data[i] <= '0;
            end
`ifdef MICRO32_DMEM_BOUNDS_EN
            pipe_err <= '0;
            st_err   <= 1'b0;
`endif
        end else begin
            pipe_valid[0] <= load_acc;
            pipe_data[0]  <= (load_acc && req_ok) ? mem[req_addr] : '0;
            for (int i = 1; i < int'(RD_LAT); i++) begin
                pipe_valid[i] <= pipe_valid[i-1];
                pipe_data[i]  <= pipe_data[i-1];
            end
`ifdef MICRO32_DMEM_BOUNDS_EN
            pipe_err[0] <= load_acc && !req_ok;
            for (int i = 1; i < int'(RD_LAT); i++) begin
                pipe_err[i] <= pipe_err[i-1];
            end
            st_err <= accept && req_we && !req_ok;
`endif
        end
    end

    assign rsp_valid = pipe_valid[RD_LAT-1];
    assign rsp_rdata = pipe_data[RD_LAT-1];

`ifdef MICRO32_DMEM_BOUNDS_EN
    assign rsp_err = pipe_err[RD_LAT-1] | st_err;
`else
    assign rsp_err = 1'b0;
`endif

endmodule
